phase_2_sampled: RTL and testbench

Sampled, parametrised successor to the asynchronous phase/frequency detector in the ring oscillator loop. It synchronises `ref` and `data` into the `clk` domain, runs a tri-state PFD state machine that drives `up`/`down`, and reports the signed phase error of each comparison in `clk` cycles. It adds a programmable reset-overlap hold, cycle-slip flagging, saturating error arithmetic and a lock detector. It sits between the oscillator taps and the digital loop filter.

---
 rtl/phase_2_sampled.sv | 181 ++++++++++++++++++
 tb/tb_phase_2_sampled.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_2_sampled.sv
// rtl/phase_2_sampled.sv - sampled tri-state phase/frequency detector
// Synchronised ref/data edges drive an up/down/hold FSM that reports signed phase error, slips and lock.
module phase_2_sampled #(
  parameter int SYNC_STAGES = 2,
  parameter int ERR_WIDTH   = 12,
  parameter int RESET_HOLD  = 1,
  parameter int LOCK_WINDOW = 2,
  parameter int LOCK_COUNT  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  // ref is a reserved word, so the reference input is named ref_sig
  input  logic                 ref_sig,
  input  logic                 data,
  output logic                 up,
  output logic                 down,
  output logic [ERR_WIDTH-1:0] phase_err,
  output logic                 err_valid,
  output logic                 slip,
  output logic                 locked
);

  localparam int CW = ERR_WIDTH - 1;
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [3:0]    HOLD_LAST = 4'(RESET_HOLD);
  localparam logic [7:0]    LOCK_MAX  = 8'(LOCK_COUNT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_UP,
    S_DOWN,
    S_HOLD
  } state_t;

  state_t state, state_n;

  logic [SYNC_STAGES-1:0] ref_sync, data_sync;
  logic                   ref_dly, data_dly;
  logic                   ref_rise, data_rise;

  logic [CW-1:0] cnt, cnt_n, cnt_inc, err_mag;
  logic [3:0]    hold_cnt, hold_n;
  logic [7:0]    lock_cnt, lock_n;
  logic          done, err_neg, slip_n, in_window;
  logic [ERR_WIDTH-1:0] mag_ext;
  state_t        after_cmp;

  // Edge detectors run regardless of enable so edges seen while disabled are consumed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ref_sync  <= '0;
      data_sync <= '0;
      ref_dly   <= 1'b0;
      data_dly  <= 1'b0;
    end else begin
      ref_sync  <= {ref_sync[SYNC_STAGES-2:0], ref_sig};
      data_sync <= {data_sync[SYNC_STAGES-2:0], data};
      ref_dly   <= ref_sync[SYNC_STAGES-1];
      data_dly  <= data_sync[SYNC_STAGES-1];
    end
  end

  assign ref_rise  = ref_sync[SYNC_STAGES-1] & ~ref_dly;
  assign data_rise = data_sync[SYNC_STAGES-1] & ~data_dly;

  // Magnitude counter saturates at all-ones, which keeps the error range symmetric.
  assign cnt_inc   = (&cnt) ? cnt : cnt + CNT_ONE;
  assign after_cmp = (RESET_HOLD == 0) ? S_IDLE : S_HOLD;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    hold_n  = hold_cnt;
    done    = 1'b0;
    err_mag = '0;
    err_neg = 1'b0;
    slip_n  = 1'b0;
    if (!enable) begin
      state_n = S_IDLE;
      cnt_n   = '0;
      hold_n  = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ref_rise && data_rise) begin
            done    = 1'b1;
            state_n = after_cmp;
            hold_n  = 4'd1;
          end else if (ref_rise) begin
            state_n = S_UP;
            cnt_n   = CNT_ONE;
          end else if (data_rise) begin
            state_n = S_DOWN;
            cnt_n   = CNT_ONE;
          end
        end
        S_UP: begin
          if (data_rise) begin
            done    = 1'b1;
            err_mag = cnt;
            state_n = after_cmp;
            hold_n  = 4'd1;
            cnt_n   = '0;
          end else begin
            cnt_n  = cnt_inc;
            slip_n = ref_rise;
          end
        end
        S_DOWN: begin
          if (ref_rise) begin
            done    = 1'b1;
            err_mag = cnt;
            err_neg = 1'b1;
            state_n = after_cmp;
            hold_n  = 4'd1;
            cnt_n   = '0;
          end else begin
            cnt_n  = cnt_inc;
            slip_n = data_rise;
          end
        end
        S_HOLD: begin
          // Edges arriving during the overlap are ignored.
          if (hold_cnt >= HOLD_LAST) begin
            state_n = S_IDLE;
            hold_n  = '0;
          end else begin
            hold_n = hold_cnt + 4'd1;
          end
        end
        default: begin
          state_n = S_IDLE;
          cnt_n   = '0;
          hold_n  = '0;
        end
      endcase
    end
  end

  assign in_window = (32'(err_mag) <= 32'(LOCK_WINDOW));
  assign mag_ext   = {1'b0, err_mag};

  always_comb begin
    lock_n = lock_cnt;
    if (!enable || slip_n || (done && !in_window)) begin
      lock_n = '0;
    end else if (done && (lock_cnt < LOCK_MAX)) begin
      lock_n = lock_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      hold_cnt  <= '0;
      lock_cnt  <= '0;
      up        <= 1'b0;
      down      <= 1'b0;
      phase_err <= '0;
      err_valid <= 1'b0;
      slip      <= 1'b0;
      locked    <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      hold_cnt  <= hold_n;
      lock_cnt  <= lock_n;
      up        <= (state_n == S_UP) || (state_n == S_HOLD);
      down      <= (state_n == S_DOWN) || (state_n == S_HOLD);
      err_valid <= done;
      slip      <= slip_n;
      locked    <= (lock_n == LOCK_MAX);
      if (done) begin
        phase_err <= err_neg ? ('0 - mag_ext) : mag_ext;
      end
    end
  end

endmodule

// File: tb/tb_phase_2_sampled.sv
// tb/tb_phase_2_sampled.sv - directed bench for phase_2_sampled
// Three instances: defaults, RESET_HOLD=0, ERR_WIDTH=4, sharing one set of inputs.
module tb_phase_2_sampled;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b1;
  logic ref_s = 1'b0;
  logic data_s = 1'b0;

  logic [2:0] up_v, down_v, ev_v, slip_v, lock_v;
  logic [11:0] pe_a, pe_b;
  logic [3:0]  pe_c;

  int checks = 0;
  int errors = 0;

  int n_up[3], n_dn[3], n_ovl[3], n_valid[3], n_slip[3], last_err[3];
  logic lock_at_valid[3];
  logic [1:0] ud_at_valid[3];

  always #5 clk = ~clk;

  phase_2_sampled dut_a (
    .clk(clk), .reset(reset), .enable(enable), .ref_sig(ref_s), .data(data_s),
    .up(up_v[0]), .down(down_v[0]), .phase_err(pe_a), .err_valid(ev_v[0]),
    .slip(slip_v[0]), .locked(lock_v[0])
  );

  phase_2_sampled #(.RESET_HOLD(0)) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .ref_sig(ref_s), .data(data_s),
    .up(up_v[1]), .down(down_v[1]), .phase_err(pe_b), .err_valid(ev_v[1]),
    .slip(slip_v[1]), .locked(lock_v[1])
  );

  phase_2_sampled #(.ERR_WIDTH(4)) dut_c (
    .clk(clk), .reset(reset), .enable(enable), .ref_sig(ref_s), .data(data_s),
    .up(up_v[2]), .down(down_v[2]), .phase_err(pe_c), .err_valid(ev_v[2]),
    .slip(slip_v[2]), .locked(lock_v[2])
  );

  task automatic clear_obs();
    for (int i = 0; i < 3; i++) begin
      n_up[i] = 0; n_dn[i] = 0; n_ovl[i] = 0; n_valid[i] = 0; n_slip[i] = 0;
      last_err[i] = -999; lock_at_valid[i] = 1'bx; ud_at_valid[i] = 2'bxx;
    end
  endtask

  task automatic tick_obs();
    int e[3];
    @(posedge clk);
    #1;
    e[0] = int'($signed(pe_a));
    e[1] = int'($signed(pe_b));
    e[2] = int'($signed(pe_c));
    for (int i = 0; i < 3; i++) begin
      if (up_v[i] && !down_v[i]) n_up[i]++;
      if (down_v[i] && !up_v[i]) n_dn[i]++;
      if (up_v[i] && down_v[i]) n_ovl[i]++;
      if (slip_v[i]) n_slip[i]++;
      if (ev_v[i]) begin
        n_valid[i]++;
        last_err[i] = e[i];
        lock_at_valid[i] = lock_v[i];
        ud_at_valid[i] = {up_v[i], down_v[i]};
      end
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick_obs();
  endtask

  task automatic do_reset();
    ref_s = 1'b0; data_s = 1'b0; enable = 1'b1; reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    ticks(4);
    clear_obs();
  endtask

  // Positive lead: ref rises |lead| cycles before data; negative: data first.
  task automatic run_pair(input int lead);
    int gap;
    gap = (lead < 0) ? -lead : lead;
    clear_obs();
    if (lead >= 0) ref_s = 1'b1; else data_s = 1'b1;
    ticks(gap);
    ref_s = 1'b1; data_s = 1'b1;
    ticks(10);
    ref_s = 1'b0; data_s = 1'b0;
    ticks(6);
  endtask

  task automatic test_reset();
    ref_s = 1'b0; data_s = 1'b0; reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    if ({up_v, down_v, ev_v, slip_v, lock_v} !== 15'd0) begin
      errors++; $display("FAIL reset_outputs got %b want 0", {up_v, down_v, ev_v, slip_v, lock_v});
    end
    checks++;
    if (pe_a !== 12'd0 || pe_c !== 4'd0) begin
      errors++; $display("FAIL reset_phase_err got %0h/%0h want 0", pe_a, pe_c);
    end
    checks++;
    do_reset();
    if (up_v[0] !== 1'b0 || down_v[0] !== 1'b0) begin
      errors++; $display("FAIL reset_idle got %b%b want 00", up_v[0], down_v[0]);
    end
    checks++;
  endtask

  task automatic test_ref_leads();
    do_reset();
    run_pair(5);
    if (n_up[0] !== 5) begin errors++; $display("FAIL ref_leads_up_cycles got %0d want 5", n_up[0]); end
    checks++;
    if (n_valid[0] !== 1) begin errors++; $display("FAIL ref_leads_valid_count got %0d want 1", n_valid[0]); end
    checks++;
    if (last_err[0] !== 5) begin errors++; $display("FAIL ref_leads_err got %0d want 5", last_err[0]); end
    checks++;
    if (ud_at_valid[0] !== 2'b11 || n_ovl[0] !== 1) begin
      errors++; $display("FAIL ref_leads_hold got %b/%0d want 11/1", ud_at_valid[0], n_ovl[0]);
    end
    checks++;
    if (n_dn[0] !== 0 || up_v[0] !== 1'b0) begin
      errors++; $display("FAIL ref_leads_idle got dn=%0d up=%b want 0/0", n_dn[0], up_v[0]);
    end
    checks++;
  endtask

  task automatic test_data_leads_no_hold();
    do_reset();
    run_pair(-3);
    if (n_dn[1] !== 3) begin errors++; $display("FAIL data_leads_down_cycles got %0d want 3", n_dn[1]); end
    checks++;
    if (last_err[1] !== -3 || n_valid[1] !== 1) begin
      errors++; $display("FAIL data_leads_err got %0d x%0d want -3 x1", last_err[1], n_valid[1]);
    end
    checks++;
    if (n_ovl[1] !== 0 || ud_at_valid[1] !== 2'b00) begin
      errors++; $display("FAIL data_leads_no_overlap got %0d/%b want 0/00", n_ovl[1], ud_at_valid[1]);
    end
    checks++;
    if (last_err[0] !== -3 || n_ovl[0] !== 1) begin
      errors++; $display("FAIL data_leads_default got %0d/%0d want -3/1", last_err[0], n_ovl[0]);
    end
    checks++;
  endtask

  task automatic test_simultaneous();
    do_reset();
    run_pair(0);
    if (n_valid[0] !== 1 || last_err[0] !== 0) begin
      errors++; $display("FAIL simul_err got %0d x%0d want 0 x1", last_err[0], n_valid[0]);
    end
    checks++;
    if (n_up[0] !== 0 || n_dn[0] !== 0) begin
      errors++; $display("FAIL simul_alone got up=%0d dn=%0d want 0/0", n_up[0], n_dn[0]);
    end
    checks++;
    if (ud_at_valid[0] !== 2'b11) begin
      errors++; $display("FAIL simul_hold got %b want 11", ud_at_valid[0]);
    end
    checks++;
  endtask

  task automatic test_slip_saturate();
    do_reset();
    ref_s = 1'b1; ticks(3);
    ref_s = 1'b0; ticks(7);
    ref_s = 1'b1; ticks(4);
    data_s = 1'b1; ticks(10);
    ref_s = 1'b0; data_s = 1'b0; ticks(6);
    if (n_slip[2] !== 1) begin errors++; $display("FAIL slip_count got %0d want 1", n_slip[2]); end
    checks++;
    if (last_err[2] !== 7 || n_valid[2] !== 1) begin
      errors++; $display("FAIL slip_sat_err got %0d x%0d want 7 x1", last_err[2], n_valid[2]);
    end
    checks++;
    if (lock_at_valid[2] !== 1'b0) begin
      errors++; $display("FAIL slip_locked got %b want 0", lock_at_valid[2]);
    end
    checks++;
    if (last_err[0] !== 14) begin errors++; $display("FAIL slip_wide_err got %0d want 14", last_err[0]); end
    checks++;
  endtask

  task automatic test_lock();
    int want;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      want = (i % 2 == 0) ? 1 : -2;
      run_pair(want);
      if (last_err[0] !== want || lock_at_valid[0] !== (i == 7)) begin
        errors++;
        $display("FAIL lock_step%0d got err=%0d lock=%b want err=%0d lock=%b",
                 i, last_err[0], lock_at_valid[0], want, (i == 7));
      end
      checks++;
    end
    run_pair(3);
    if (last_err[0] !== 3 || lock_at_valid[0] !== 1'b0) begin
      errors++; $display("FAIL lock_drop got err=%0d lock=%b want 3/0", last_err[0], lock_at_valid[0]);
    end
    checks++;
  endtask

  task automatic test_enable();
    do_reset();
    run_pair(2);
    clear_obs();
    ref_s = 1'b1; ticks(4);
    if (up_v[0] !== 1'b1) begin errors++; $display("FAIL enable_pre_up got %b want 1", up_v[0]); end
    checks++;
    enable = 1'b0;
    clear_obs();
    tick_obs();
    if (up_v[0] !== 1'b0) begin errors++; $display("FAIL enable_off_up got %b want 0", up_v[0]); end
    checks++;
    data_s = 1'b1; ticks(10);
    if (n_valid[0] !== 0 || n_up[0] + n_dn[0] + n_ovl[0] !== 0 || pe_a !== 12'd2) begin
      errors++; $display("FAIL enable_off_quiet got v=%0d act=%0d pe=%0d want 0/0/2",
                         n_valid[0], n_up[0] + n_dn[0] + n_ovl[0], pe_a);
    end
    checks++;
    enable = 1'b1; ticks(6);
    if (n_valid[0] !== 0 || n_up[0] + n_dn[0] + n_ovl[0] !== 0) begin
      errors++; $display("FAIL enable_discard got v=%0d act=%0d want 0/0", n_valid[0], n_up[0] + n_dn[0] + n_ovl[0]);
    end
    checks++;
    ref_s = 1'b0; data_s = 1'b0; ticks(6);
  endtask

  task automatic test_async_reset();
    do_reset();
    run_pair(2);
    clear_obs();
    ref_s = 1'b1; ticks(6);
    if (up_v[0] !== 1'b1 || pe_a !== 12'd2) begin
      errors++; $display("FAIL areset_pre got up=%b pe=%0d want 1/2", up_v[0], pe_a);
    end
    checks++;
    #2 reset = 1'b1;
    #1;
    if ({up_v[0], down_v[0], ev_v[0], slip_v[0], lock_v[0]} !== 5'd0 || pe_a !== 12'd0) begin
      errors++; $display("FAIL areset_clear got %b pe=%0d want 00000/0",
                         {up_v[0], down_v[0], ev_v[0], slip_v[0], lock_v[0]}, pe_a);
    end
    checks++;
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    clear_obs();
    ticks(12);
    if (n_up[0] !== 10 || n_slip[0] !== 0 || n_valid[0] !== 0) begin
      errors++; $display("FAIL areset_one_rise got up=%0d slip=%0d v=%0d want 10/0/0",
                         n_up[0], n_slip[0], n_valid[0]);
    end
    checks++;
    data_s = 1'b1; ticks(10);
    if (n_valid[0] !== 1 || last_err[0] !== 12) begin
      errors++; $display("FAIL areset_err got %0d x%0d want 12 x1", last_err[0], n_valid[0]);
    end
    checks++;
    ref_s = 1'b0; data_s = 1'b0; ticks(6);
  endtask

  initial begin
    clear_obs();
    test_reset();
    test_ref_leads();
    test_data_leads_no_hold();
    test_simultaneous();
    test_slip_saturate();
    test_lock();
    test_enable();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
